// File: rtl/dac_update_scheduler_if.sv
// Producer ingress handshake and serial DAC driver strobe bundle for dac_update_scheduler.
interface dac_update_scheduler_if #(
    parameter int DATA_W = 12
);
    logic [1:0]        ch_valid;
    logic [1:0]        ch_ready;
    logic [DATA_W-1:0] ch_data0;
    logic [DATA_W-1:0] ch_data1;
    logic              drv_ready;
    logic              drv_go;
    logic              drv_sel;
    logic [DATA_W-1:0] drv_data;

    modport master (
        input  ch_valid, ch_data0, ch_data1, drv_ready,
        output ch_ready, drv_go, drv_sel, drv_data
    );

    modport slave (
        output ch_valid, ch_data0, ch_data1, drv_ready,
        input  ch_ready, drv_go, drv_sel, drv_data
    );
endinterface

// File: rtl/dac_update_scheduler.sv
// Paces a shared dual-channel DAC driver: per-channel holding registers, a sample-rate tick,
// and an FSM issuing ch0 then ch1 each period, with saturating underrun/late counters.
//
// state     | meaning
// IDLE      | waiting for a sample tick
// ISSUE     | presenting go for the lowest due channel, waiting for drv_ready
// WAIT_ACK  | go accepted, waiting for the driver to drop ready
// WAIT_DONE | driver converting, waiting for ready to return
module dac_update_scheduler #(
    parameter int DATA_W   = 12,
    parameter int RATE_DIV = 64,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    dac_update_scheduler_if.master  bus,
    output logic                    sample_tick,
    output logic                    busy,
    output logic [CNT_W-1:0]        underrun_cnt0,
    output logic [CNT_W-1:0]        underrun_cnt1,
    output logic [CNT_W-1:0]        late_cnt
);
    localparam int               PW      = $clog2(RATE_DIV);
    localparam logic [PW-1:0]    TC      = PW'(RATE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     rate_cnt;
    logic [1:0]        pending, due, accept, issue_mask;
    logic [DATA_W-1:0] hold0, hold1;
    logic              tick, sel, go, load_sel, enter_issue;

    assign tick        = enable && (rate_cnt == TC) && !rst;
    assign sample_tick = tick;
    assign sel         = ~due[0];
    assign accept      = bus.ch_valid & ~pending & {2{!rst}};
    assign issue_mask  = go ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign enter_issue = (state_nxt == ISSUE) && (state != ISSUE);
    // Entering from IDLE the due set is about to become pending, otherwise it is due itself.
    assign load_sel    = (state == IDLE) ? ~pending[0] : ~due[0];

    always_ff @(posedge clk) begin
        if (rst || !enable)    rate_cnt <= '0;
        else if (rate_cnt == TC) rate_cnt <= '0;
        else                   rate_cnt <= rate_cnt + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (tick && (pending != 2'b00)) state_nxt = ISSUE;
            ISSUE:     if (bus.drv_ready) state_nxt = WAIT_ACK;
            WAIT_ACK:  if (!bus.drv_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.drv_ready) state_nxt = (due != 2'b00) ? ISSUE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        go           = (state == ISSUE) && bus.drv_ready && !rst;
        busy         = (state != IDLE);
        bus.drv_go   = go;
        bus.ch_ready = rst ? 2'b00 : ~pending;
    end

    always_ff @(posedge clk) begin
        if (accept[0]) hold0 <= bus.ch_data0;
        if (accept[1]) hold1 <= bus.ch_data1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= 2'b00;
            due           <= 2'b00;
            bus.drv_sel   <= 1'b0;
            bus.drv_data  <= '0;
            underrun_cnt0 <= '0;
            underrun_cnt1 <= '0;
            late_cnt      <= '0;
        end else begin
            pending <= (pending | accept) & ~issue_mask;
            if (tick && state == IDLE) due <= pending;
            else if (go)               due <= due & ~issue_mask;

            // Preloading on ISSUE entry keeps sel/data valid throughout the go cycle.
            if (enter_issue) begin
                bus.drv_sel  <= load_sel;
                bus.drv_data <= load_sel ? hold1 : hold0;
            end else if (go) begin
                bus.drv_sel  <= sel;
                bus.drv_data <= sel ? hold1 : hold0;
            end

            if (tick && state == IDLE) begin
                if (!pending[0] && underrun_cnt0 != CNT_MAX) underrun_cnt0 <= underrun_cnt0 + CNT_W'(1);
                if (!pending[1] && underrun_cnt1 != CNT_MAX) underrun_cnt1 <= underrun_cnt1 + CNT_W'(1);
            end
            if (tick && state != IDLE && late_cnt != CNT_MAX) late_cnt <= late_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dac_update_scheduler.sv
// Self-checking bench for dac_update_scheduler: vector table plus scoreboard of expected driver transfers.
module tb_dac_update_scheduler;
    localparam int DATA_W = 12, RATE_DIV = 64, CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, enable;
    logic             sample_tick, busy;
    logic [CNT_W-1:0] ur0, ur1, late;

    dac_update_scheduler_if #(.DATA_W(DATA_W)) bus();

    dac_update_scheduler #(.DATA_W(DATA_W), .RATE_DIV(RATE_DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus),
        .sample_tick(sample_tick), .busy(busy),
        .underrun_cnt0(ur0), .underrun_cnt1(ur1), .late_cnt(late)
    );

    always #5 clk = ~clk;

    typedef struct { logic sel; logic [11:0] data; } exp_t;
    typedef struct { bit v0; logic [11:0] d0; bit v1; logic [11:0] d1; int gos; int ur0; int ur1; } vec_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_pass = 0;
    int   go_total = 0;
    bit   saw_low = 1'b1;
    int   drv_busy_len = 16;
    bit   drv_stall = 1'b0;
    int   busy_left = 0, last_go = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endfunction

    // Transfer monitor: pops the scoreboard on each go.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) saw_low = 1'b1;
        else begin
            if (!bus.drv_ready) saw_low = 1'b1;
            if (bus.drv_go) begin
                go_total++;
                chk("go_spacing", int'(saw_low), 1);
                saw_low = 1'b0;
                chk("go_expected", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("go_sel", int'(bus.drv_sel), int'(e.sel));
                    chk("go_data", int'(bus.drv_data), int'(e.data));
                end
            end
        end
    end

    // Driver model: ready drops after the go edge for drv_busy_len cycles.
    initial begin
        bus.drv_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                busy_left = 0;
                last_go   = go_total;
            end else if (go_total != last_go) begin
                last_go   = go_total;
                busy_left = drv_busy_len;
            end else if (busy_left > 0) busy_left--;
            bus.drv_ready = (busy_left == 0) && !drv_stall;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(string name);
        int k = 0;
        @(negedge clk);
        while (!sample_tick && k < 200) begin @(negedge clk); k++; end
        chk(name, int'(sample_tick), 1);
    endtask

    task automatic load(bit v0, logic [11:0] d0, bit v1, logic [11:0] d1);
        int   k = 0;
        logic [1:0] m;
        exp_t e;
        m = {v1, v0};
        bus.ch_valid = m; bus.ch_data0 = d0; bus.ch_data1 = d1;
        if (m != 2'b00) begin
            while ((bus.ch_ready & m) != m && k < 200) begin @(negedge clk); k++; end
            chk("load_ready", int'(bus.ch_ready & m), int'(m));
            @(posedge clk);
            if (v0) begin e.sel = 1'b0; e.data = d0; sb_q.push_back(e); end
            if (v1) begin e.sel = 1'b1; e.data = d1; sb_q.push_back(e); end
        end
        @(negedge clk);
        bus.ch_valid = 2'b00;
    endtask

    initial begin
        vec_t tbl[5];
        int   g0, u0, u1, l0, k, tcnt;
        exp_t e;

        tbl[0] = '{1'b1, 12'h123, 1'b1, 12'hABC, 2, 0, 0};
        tbl[1] = '{1'b0, 12'h000, 1'b1, 12'h456, 1, 1, 0};
        tbl[2] = '{1'b1, 12'hFFF, 1'b0, 12'h000, 1, 0, 1};
        tbl[3] = '{1'b0, 12'h000, 1'b0, 12'h000, 0, 1, 1};
        tbl[4] = '{1'b1, 12'h000, 1'b1, 12'h001, 2, 0, 0};

        rst = 1'b1; enable = 1'b1;
        bus.ch_valid = 2'b00; bus.ch_data0 = '0; bus.ch_data1 = '0;
        cyc(3);
        chk("rst_ready", int'(bus.ch_ready), 0);
        chk("rst_go", int'(bus.drv_go), 0);
        chk("rst_tick", int'(sample_tick), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(bus.ch_ready), 3);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_cnts", int'({ur0, ur1, late}), 0);
        chk("post_rst_data", int'(bus.drv_data), 0);

        for (int i = 0; i < 5; i++) begin
            load(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            g0 = go_total; u0 = ur0; u1 = ur1; l0 = late;
            wait_tick("vec_tick");
            cyc(55);
            chk("vec_gos", go_total - g0, tbl[i].gos);
            chk("vec_ur0", int'(ur0) - u0, tbl[i].ur0);
            chk("vec_ur1", int'(ur1) - u1, tbl[i].ur1);
            chk("vec_late", int'(late) - l0, 0);
            chk("vec_ready", int'(bus.ch_ready), 3);
            chk("vec_busy", int'(busy), 0);
            chk("vec_sb_empty", sb_q.size(), 0);
        end

        // Reset in the middle of a two-channel sequence.
        load(1'b1, 12'h077, 1'b1, 12'h088);
        wait_tick("mid_tick");
        cyc(5);
        chk("mid_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_go", int'(bus.drv_go), 0);
        chk("mid_rst_ready", int'(bus.ch_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("mid_post_ready", int'(bus.ch_ready), 3);
        chk("mid_post_busy", int'(busy), 0);
        chk("mid_post_go", int'(bus.drv_go), 0);
        chk("mid_post_cnts", int'({ur0, ur1, late}), 0);

        // Tick pacing boundaries.
        enable = 1'b0;
        tcnt = 0;
        for (int i = 0; i < 150; i++) begin @(negedge clk); tcnt += int'(sample_tick); end
        chk("disabled_ticks", tcnt, 0);
        enable = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!sample_tick && k < 200);
        chk("first_tick_delay", k, RATE_DIV - 1);
        k = 0;
        do begin @(negedge clk); k++; end while (!sample_tick && k < 200);
        chk("tick_period", k, RATE_DIV);

        // Driver stalled across a tick.
        cyc(56);
        load(1'b1, 12'h321, 1'b0, 12'h000);
        g0 = go_total;
        drv_stall = 1'b1;
        wait_tick("stall_tick");
        cyc(4);
        chk("stall_no_go", go_total - g0, 0);
        chk("stall_busy", int'(busy), 1);
        chk("stall_go_now", int'(bus.drv_go), 0);
        drv_stall = 1'b0;
        cyc(40);
        chk("stall_one_go", go_total - g0, 1);
        chk("stall_sb_empty", sb_q.size(), 0);

        // Slow driver: ticks during the sequence are counted late and dropped.
        drv_busy_len = 100;
        load(1'b1, 12'h5A5, 1'b1, 12'h0F0);
        g0 = go_total; l0 = late;
        wait_tick("late_tick");
        cyc(240);
        chk("late_cnt3", int'(late) - l0, 3);
        chk("late_gos", go_total - g0, 2);
        chk("late_idle", int'(busy), 0);
        load(1'b1, 12'h111, 1'b1, 12'h222);
        drv_busy_len = 16;
        wait_tick("late_tick2");
        cyc(55);
        chk("late_cnt_after", int'(late) - l0, 3);
        chk("late_gos_after", go_total - g0, 4);
        chk("late_sb_empty", sb_q.size(), 0);

        // Producer keeps offering while its holding register is full.
        load(1'b1, 12'h123, 1'b0, 12'h000);
        bus.ch_valid = 2'b01; bus.ch_data0 = 12'h555;
        k = 0;
        while (!bus.drv_go && k < 200) begin @(negedge clk); k++; end
        chk("hold_go_seen", int'(bus.drv_go), 1);
        chk("hold_ready_in_go", int'(bus.ch_ready[0]), 0);
        @(negedge clk);
        chk("hold_ready_after_go", int'(bus.ch_ready[0]), 1);
        e.sel = 1'b0; e.data = 12'h555; sb_q.push_back(e);
        @(negedge clk);
        chk("hold_reaccepted", int'(bus.ch_ready[0]), 0);
        bus.ch_valid = 2'b00;
        wait_tick("hold_tick");
        cyc(55);
        chk("hold_sb_empty", sb_q.size(), 0);

        // Underrun counters saturate.
        l0 = late;
        tcnt = 0;
        for (int i = 0; i < 300 * RATE_DIV + 200 && tcnt < 300; i++) begin
            @(negedge clk);
            tcnt += int'(sample_tick);
        end
        chk("sat_ticks", tcnt, 300);
        chk("sat_ur0", int'(ur0), 255);
        chk("sat_ur1", int'(ur1), 255);
        chk("sat_late", int'(late), l0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
